// File: rtl/dae_issue_controller.sv
// Issue/sequencing front end for an external combinational Decode_And_Execute ALU:
// queues 9-bit instructions, reads operands from a 4x4 register file, writes results back.
module dae_issue_controller #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inst_valid,
    output logic       inst_ready,
    input  logic [8:0] inst,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    input  logic [1:0] rf_addr,
    output logic [3:0] rf_data,
    output logic [3:0] alu_rs,
    output logic [3:0] alu_rt,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_rd,
    output logic       done,
    output logic [1:0] done_dst,
    output logic [3:0] done_data,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t         state, state_next;
    logic [8:0]     fifo [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [3:0]     rf [4];
    logic [1:0]     exec_dst;
    logic [8:0]     head;
    logic           full, push, pop;

    assign full       = (count == FULL_CNT);
    assign inst_ready = !full;
    assign push       = inst_valid && inst_ready;
    assign busy       = (state != IDLE) || (count != '0);
    assign head       = fifo[rd_ptr];
    assign rf_data    = rf[rf_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_rs   <= 4'h0;
            alu_rt   <= 4'h0;
            alu_sel  <= 3'b000;
            exec_dst <= 2'b00;
        end else if (pop) begin
            alu_rs   <= rf[head[3:2]];
            alu_rt   <= rf[head[1:0]];
            alu_sel  <= head[8:6];
            exec_dst <= head[5:4];
        end
    end

    // Writeback and direct loads never collide: a load is only honoured while not busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
        end else if (state == EXEC) begin
            rf[exec_dst] <= alu_rd;
        end else if (ld_en && !busy) begin
            rf[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            done_dst  <= 2'b00;
            done_data <= 4'h0;
        end else begin
            done <= (state == EXEC);
            if (state == EXEC) begin
                done_dst  <= exec_dst;
                done_data <= alu_rd;
            end
        end
    end

endmodule

// File: tb/tb_dae_issue_controller.sv
// Directed bench for dae_issue_controller with a small stand-in combinational ALU.
module tb_dae_issue_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inst_valid;
    logic       inst_ready;
    logic [8:0] inst;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [1:0] rf_addr;
    logic [3:0] rf_data;
    logic [3:0] alu_rs, alu_rt, alu_rd;
    logic [2:0] alu_sel;
    logic       done;
    logic [1:0] done_dst;
    logic [3:0] done_data;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_count = 0;

    typedef struct packed {
        logic [1:0] dst;
        logic [3:0] data;
        int         cyc;
    } done_t;
    done_t done_log[$];

    dae_issue_controller #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_sel(alu_sel), .alu_rd(alu_rd),
        .done(done), .done_dst(done_dst), .done_data(done_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU; the controller only passes its result through.
    function automatic logic [3:0] alu_model(input logic [3:0] rs, input logic [3:0] rt,
                                             input logic [2:0] sel);
        logic [3:0] sh;
        sh = rs << 1;
        case (sel)
            3'b000:  return rs - rt;
            3'b001:  return rs + rt;
            3'b010:  return rs & rt;
            3'b011:  return rs | rt;
            3'b100:  return rs ^ rt;
            3'b110:  return ~sh;
            3'b111:  return rt;
            default: return 4'h0;
        endcase
    endfunction

    always_comb alu_rd = alu_model(alu_rs, alu_rt, alu_sel);

    always @(negedge clk) begin
        cycle_count <= cycle_count + 1;
        if (rst_n && done) done_log.push_back('{dst: done_dst, data: done_data, cyc: cycle_count});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadReg(input logic [1:0] a, input logic [3:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] sel, input logic [1:0] dst,
                                 input logic [1:0] s1, input logic [1:0] s2);
        inst       = {sel, dst, s1, s2};
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [3:0] expected);
        rf_addr = a;
        #1;
        checkOutput(tag, 32'(rf_data), 32'(expected));
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        checkOutput("idle timeout", 32'(busy), 32'd0);
    endtask

    task automatic waitDones(input int n, input int bound);
        int k = 0;
        while (done_log.size() < n && k < bound) begin
            tick();
            k++;
        end
        checkOutput("done count", 32'(done_log.size()), 32'(n));
    endtask

    initial begin
        logic exp_ready [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] t4_vals [3] = '{4'd10, 4'd11, 4'd12};
        int idx;

        rst_n = 1'b0; inst_valid = 1'b0; inst = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rf_addr = '0;

        // Reset state
        #12;
        checkOutput("rst inst_ready", 32'(inst_ready), 32'd1);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst alu_sel", 32'(alu_sel), 32'd0);
        checkOutput("rst done_data", 32'(done_data), 32'd0);
        checkReg("rst rf0", 2'd0, 4'h0);
        rst_n = 1'b1;
        tick();

        // 1: add with exact latency
        loadReg(2'd0, 4'd5);
        loadReg(2'd1, 4'd3);
        applyStimulus(3'b001, 2'd2, 2'd0, 2'd1);
        checkOutput("t1 busy after push", 32'(busy), 32'd1);
        tick();
        checkOutput("t1 alu_rs", 32'(alu_rs), 32'd5);
        checkOutput("t1 alu_rt", 32'(alu_rt), 32'd3);
        checkOutput("t1 alu_sel", 32'(alu_sel), 32'd1);
        checkOutput("t1 no early done", 32'(done), 32'd0);
        tick();
        checkOutput("t1 done", 32'(done), 32'd1);
        checkOutput("t1 done_dst", 32'(done_dst), 32'd2);
        checkOutput("t1 done_data", 32'(done_data), 32'd8);
        checkReg("t1 rf2", 2'd2, 4'd8);
        tick();
        checkOutput("t1 done falls", 32'(done), 32'd0);
        checkOutput("t1 done_data holds", 32'(done_data), 32'd8);
        checkOutput("t1 idle", 32'(busy), 32'd0);

        // 2: subtract wrap, then opcode 110, two cycles apart
        loadReg(2'd0, 4'd2);
        loadReg(2'd1, 4'd5);
        done_log.delete();
        applyStimulus(3'b000, 2'd3, 2'd0, 2'd1);
        applyStimulus(3'b110, 2'd2, 2'd0, 2'd1);
        waitDones(2, 20);
        if (done_log.size() >= 2) begin
            checkOutput("t2 d0 data", 32'(done_log[0].data), 32'hD);
            checkOutput("t2 d0 dst", 32'(done_log[0].dst), 32'd3);
            checkOutput("t2 d1 data", 32'(done_log[1].data), 32'hB);
            checkOutput("t2 d1 dst", 32'(done_log[1].dst), 32'd2);
            checkOutput("t2 spacing", 32'(done_log[1].cyc - done_log[0].cyc), 32'd2);
        end
        checkReg("t2 rf3", 2'd3, 4'hD);
        waitIdle(10);

        // 3: RAW chain on R0
        loadReg(2'd0, 4'd1);
        done_log.delete();
        for (int i = 0; i < 3; i++) applyStimulus(3'b001, 2'd0, 2'd0, 2'd0);
        waitDones(3, 30);
        if (done_log.size() >= 3) begin
            checkOutput("t3 d0", 32'(done_log[0].data), 32'd2);
            checkOutput("t3 d1", 32'(done_log[1].data), 32'd4);
            checkOutput("t3 d2", 32'(done_log[2].data), 32'd8);
        end
        waitIdle(10);
        checkReg("t3 rf0", 2'd0, 4'd8);

        // 4: fill the FIFO while the ALU keeps draining
        loadReg(2'd0, 4'd10);
        loadReg(2'd1, 4'd11);
        loadReg(2'd2, 4'd12);
        done_log.delete();
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            inst       = {3'b111, 2'd3, 2'd0, 2'(idx % 3)};
            inst_valid = 1'b1;
            checkOutput($sformatf("t4 ready c%0d", c), 32'(inst_ready), 32'(exp_ready[c]));
            if (inst_ready) idx++;
            tick();
        end
        inst_valid = 1'b0;
        checkOutput("t4 accepts", 32'(idx), 32'd8);
        waitDones(8, 40);
        repeat (10) tick();
        checkOutput("t4 no extra done", 32'(done_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < done_log.size(); k++)
            checkOutput($sformatf("t4 order %0d", k), 32'(done_log[k].data), 32'(t4_vals[k % 3]));
        waitIdle(10);

        // 5: load ignored while busy, honoured when idle
        applyStimulus(3'b111, 2'd3, 2'd0, 2'd0);
        tick();
        checkOutput("t5 busy in exec", 32'(busy), 32'd1);
        loadReg(2'd1, 4'd7);
        checkReg("t5 rf1 unchanged", 2'd1, 4'd11);
        waitIdle(10);
        loadReg(2'd1, 4'd7);
        checkReg("t5 rf1 loaded", 2'd1, 4'd7);

        // 6: reset during the first EXEC
        applyStimulus(3'b001, 2'd0, 2'd0, 2'd1);
        applyStimulus(3'b001, 2'd1, 2'd0, 2'd1);
        inst       = {3'b001, 2'd2, 2'd0, 2'd1};
        inst_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        inst_valid = 1'b0;
        checkOutput("t6 done", 32'(done), 32'd0);
        checkOutput("t6 inst_ready", 32'(inst_ready), 32'd1);
        checkOutput("t6 busy", 32'(busy), 32'd0);
        checkOutput("t6 alu_rs", 32'(alu_rs), 32'd0);
        checkOutput("t6 alu_rt", 32'(alu_rt), 32'd0);
        checkOutput("t6 alu_sel", 32'(alu_sel), 32'd0);
        for (int a = 0; a < 4; a++) checkReg($sformatf("t6 rf%0d", a), 2'(a), 4'h0);
        tick();
        tick();
        rst_n = 1'b1;
        done_log.delete();
        repeat (8) tick();
        checkOutput("t6 no done after reset", 32'(done_log.size()), 32'd0);
        checkOutput("t6 busy after reset", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
